// File: rtl/hls_run_pkg.sv
// hls_run_pkg
// Shared types and constants for the HLS run sequencer.
//   run_state_t : sequencer state encoding
//   ST_OK / ST_TIMEOUT : values carried on res_status
//   DEF_* : default parameter values for the sequencer top
package hls_run_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_ACC_RST,
      S_START,
      S_WAIT,
      S_REPORT
   } run_state_t;

   localparam logic [1:0] ST_OK      = 2'd0;
   localparam logic [1:0] ST_TIMEOUT = 2'd1;

   localparam int          DEF_CNT_W      = 32;
   localparam int          DEF_ITER_W     = 16;
   localparam int unsigned DEF_TIMEOUT    = 200000000;
   localparam int          DEF_RST_CYCLES = 2;

endpackage

// File: rtl/hls_cycle_counter.sv
// hls_cycle_counter
// Latency counter for one accelerator run. Loads 1 on the edge that
// enters the start-pulse cycle, then counts up while enabled and
// saturates at LIMIT so it can never wrap.
//   clock, reset : rising-edge clock, async active-high reset
//   load         : force count to 1 on the next edge
//   enable       : count up on the next edge (ignored at LIMIT)
//   count        : current cycle count
//   at_limit     : count has reached LIMIT
module hls_cycle_counter #(
   parameter int          CNT_W = 32,
   parameter int unsigned LIMIT = 200000000
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             load,
   input  logic             enable,
   output logic [CNT_W-1:0] count,
   output logic             at_limit
);

   localparam logic [CNT_W-1:0] LIMIT_V = CNT_W'(LIMIT);

   // Load wins over enable so a fresh run always restarts from 1.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         count <= '0;
      end else if (load) begin
         count <= CNT_W'(1);
      end else if (enable && (count != LIMIT_V)) begin
         count <= count + CNT_W'(1);
      end
   end

   assign at_limit = (count == LIMIT_V);

endmodule

// File: rtl/hls_run_controller.sv
// hls_run_controller
// Run sequencer in front of a Bambu-generated accelerator. For each
// accepted command it performs N runs; every run resets the accelerator
// for RST_CYCLES cycles, pulses start, measures the cycles until done
// (bounded by TIMEOUT) and emits one result record on a valid/ready
// stream.
//   clock, reset             : rising-edge clock, async active-high reset
//   cmd_valid/cmd_ready      : command handshake, cmd_runs = run count
//   acc_reset                : accelerator reset, active low
//   acc_start_port           : one-cycle start pulse
//   acc_done_port            : accelerator completion pulse
//   res_valid/res_ready      : result record handshake
//   res_status/res_cycles/res_index : record contents
//   busy                     : sequencer is not idle
//   spurious_done            : sticky, done seen outside the wait phase
// RST_CYCLES must be at least 1.
module hls_run_controller
   import hls_run_pkg::*;
#(
   parameter int          CNT_W      = DEF_CNT_W,
   parameter int          ITER_W     = DEF_ITER_W,
   parameter int unsigned TIMEOUT    = DEF_TIMEOUT,
   parameter int          RST_CYCLES = DEF_RST_CYCLES
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [ITER_W-1:0] cmd_runs,
   output logic              acc_reset,
   output logic              acc_start_port,
   input  logic              acc_done_port,
   output logic              res_valid,
   input  logic              res_ready,
   output logic [1:0]        res_status,
   output logic [CNT_W-1:0]  res_cycles,
   output logic [ITER_W-1:0] res_index,
   output logic              busy,
   output logic              spurious_done
);

   localparam int RC_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

   run_state_t        state;
   logic [RC_W-1:0]   rst_cnt;
   logic [ITER_W-1:0] runs;
   logic [CNT_W-1:0]  count;
   logic              at_limit;
   logic              rst_last;
   logic              more_runs;

   assign rst_last  = (rst_cnt == RC_W'(RST_CYCLES - 1));
   // Widened by one bit so index+1 cannot overflow at the maximum run count.
   assign more_runs = (({1'b0, res_index} + (ITER_W + 1)'(1)) < {1'b0, runs});

   // Counter is loaded on the edge into START so the start cycle itself
   // reads 1; the value captured on done then equals k+1 for a done seen
   // k cycles after the start pulse.
   hls_cycle_counter #(
      .CNT_W (CNT_W),
      .LIMIT (TIMEOUT)
   ) u_counter (
      .clock    (clock),
      .reset    (reset),
      .load     ((state == S_ACC_RST) && rst_last),
      .enable   ((state == S_START) || (state == S_WAIT)),
      .count    (count),
      .at_limit (at_limit)
   );

   // Main sequencer. All outputs are registered and updated together with
   // the state so they always describe the state being entered.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state          <= S_IDLE;
         rst_cnt        <= '0;
         runs           <= '0;
         res_index      <= '0;
         cmd_ready      <= 1'b0;
         busy           <= 1'b0;
         acc_reset      <= 1'b0;
         acc_start_port <= 1'b0;
         res_valid      <= 1'b0;
         res_status     <= ST_OK;
         res_cycles     <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               acc_reset <= 1'b1;
               if (cmd_valid && cmd_ready) begin
                  runs      <= (cmd_runs == '0) ? ITER_W'(1) : cmd_runs;
                  res_index <= '0;
                  rst_cnt   <= '0;
                  acc_reset <= 1'b0;
                  cmd_ready <= 1'b0;
                  busy      <= 1'b1;
                  state     <= S_ACC_RST;
               end else begin
                  cmd_ready <= 1'b1;
                  busy      <= 1'b0;
               end
            end
            S_ACC_RST: begin
               if (rst_last) begin
                  acc_reset      <= 1'b1;
                  acc_start_port <= 1'b1;
                  state          <= S_START;
               end else begin
                  rst_cnt <= rst_cnt + RC_W'(1);
               end
            end
            S_START: begin
               acc_start_port <= 1'b0;
               state          <= S_WAIT;
            end
            S_WAIT: begin
               // Done takes priority so a completion on the last allowed
               // cycle still reports OK.
               if (acc_done_port) begin
                  res_cycles <= count;
                  res_status <= ST_OK;
                  res_valid  <= 1'b1;
                  state      <= S_REPORT;
               end else if (at_limit) begin
                  res_cycles <= CNT_W'(TIMEOUT);
                  res_status <= ST_TIMEOUT;
                  res_valid  <= 1'b1;
                  state      <= S_REPORT;
               end
            end
            S_REPORT: begin
               if (res_ready) begin
                  res_valid <= 1'b0;
                  if (more_runs) begin
                     res_index <= res_index + ITER_W'(1);
                     rst_cnt   <= '0;
                     acc_reset <= 1'b0;
                     state     <= S_ACC_RST;
                  end else begin
                     cmd_ready <= 1'b1;
                     busy      <= 1'b0;
                     state     <= S_IDLE;
                  end
               end
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

   // A done pulse outside the wait phase points at an accelerator or
   // integration problem; remember it until the next reset.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         spurious_done <= 1'b0;
      end else if (acc_done_port && (state != S_WAIT)) begin
         spurious_done <= 1'b1;
      end
   end

endmodule

// File: tb/tb_hls_run_controller.sv
// tb_hls_run_controller
// Directed bench for hls_run_controller with a small accelerator model
// (done pulse k cycles after each start) and a record scoreboard that is
// checked on every cycle a record is presented.
module tb_hls_run_controller;

   localparam int CW  = 32;
   localparam int IW  = 16;
   localparam int TO  = 50;
   localparam int RST = 2;

   typedef struct {
      int status;
      int cycles;
      int index;
   } rec_t;

   logic          clock;
   logic          reset;
   logic          cmd_valid;
   logic          cmd_ready;
   logic [IW-1:0] cmd_runs;
   logic          acc_reset;
   logic          acc_start_port;
   logic          acc_done_port;
   logic          res_valid;
   logic          res_ready;
   logic [1:0]    res_status;
   logic [CW-1:0] res_cycles;
   logic [IW-1:0] res_index;
   logic          busy;
   logic          spurious_done;

   int   checks = 0;
   int   errors = 0;
   rec_t exp_q[$];
   rec_t got_q[$];
   int   acc_lat_q[$];
   logic exp_spurious = 1'b0;
   logic model_done   = 1'b0;
   logic inject_done  = 1'b0;
   logic acc_active   = 1'b0;
   int   acc_cnt      = 0;
   int   acc_target   = 0;
   int   low_run      = 0;
   logic prev_start   = 1'b0;
   int   edges_since_reset = 0;

   hls_run_controller #(
      .CNT_W      (CW),
      .ITER_W     (IW),
      .TIMEOUT    (TO),
      .RST_CYCLES (RST)
   ) dut (
      .clock          (clock),
      .reset          (reset),
      .cmd_valid      (cmd_valid),
      .cmd_ready      (cmd_ready),
      .cmd_runs       (cmd_runs),
      .acc_reset      (acc_reset),
      .acc_start_port (acc_start_port),
      .acc_done_port  (acc_done_port),
      .res_valid      (res_valid),
      .res_ready      (res_ready),
      .res_status     (res_status),
      .res_cycles     (res_cycles),
      .res_index      (res_index),
      .busy           (busy),
      .spurious_done  (spurious_done)
   );

   assign acc_done_port = model_done | inject_done;

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Overall time bound so the bench can never hang.
   initial begin
      #1000000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   task automatic checkOutput(input string name, input longint unsigned act, input longint unsigned req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("[TB] FAIL %s actual=%0d required=%0d", name, act, req);
      end
   endtask

   task automatic checkRecord(input int pos, input int st, input int cy, input int ix);
      if (pos < got_q.size()) begin
         checkOutput("lit_status", longint'(got_q[pos].status), longint'(st));
         checkOutput("lit_cycles", longint'(got_q[pos].cycles), longint'(cy));
         checkOutput("lit_index", longint'(got_q[pos].index), longint'(ix));
      end else begin
         checkOutput("lit_record_present", longint'(got_q.size()), longint'(pos + 1));
      end
   endtask

   // Counts clock edges since the last reset so checks skip the single
   // cycle where registered outputs still hold their reset values.
   always @(posedge clock or posedge reset) begin
      if (reset) edges_since_reset <= 0;
      else if (edges_since_reset < 4) edges_since_reset <= edges_since_reset + 1;
   end

   // Accelerator model: a start seen in cycle S yields a done pulse in
   // cycle S+k, k taken from acc_lat_q; k == 0 means the run never ends.
   always @(negedge clock) begin
      if (!reset && acc_start_port) begin
         acc_active = 1'b1;
         acc_cnt    = 0;
         acc_target = (acc_lat_q.size() > 0) ? acc_lat_q.pop_front() : 0;
      end
   end

   always @(posedge clock) begin
      #1;
      model_done = 1'b0;
      if (reset) begin
         acc_active = 1'b0;
      end else if (acc_active) begin
         acc_cnt++;
         if (acc_target != 0 && acc_cnt == acc_target) begin
            model_done = 1'b1;
            acc_active = 1'b0;
         end
      end
   end

   // Per-cycle compare against the scoreboard and the reset/start rules.
   always @(negedge clock) begin
      rec_t act;
      if (reset || edges_since_reset == 0) begin
         low_run    = 0;
         prev_start = 1'b0;
      end else begin
         checkOutput("spurious_done", spurious_done, exp_spurious);
         if (acc_start_port) begin
            checkOutput("rst_low_before_start", longint'(low_run), longint'(RST));
            checkOutput("start_while_record", res_valid, 0);
            checkOutput("start_pulse_width", prev_start, 0);
         end
         prev_start = acc_start_port;
         low_run    = acc_reset ? 0 : low_run + 1;
         if (res_valid) begin
            if (exp_q.size() == 0) begin
               checkOutput("unexpected_record", 1, 0);
            end else begin
               act.status = int'(res_status);
               act.cycles = int'(res_cycles);
               act.index  = int'(res_index);
               checkOutput("rec_status", longint'(act.status), longint'(exp_q[0].status));
               checkOutput("rec_cycles", longint'(act.cycles), longint'(exp_q[0].cycles));
               checkOutput("rec_index", longint'(act.index), longint'(exp_q[0].index));
               if (res_ready) begin
                  got_q.push_back(act);
                  void'(exp_q.pop_front());
               end
            end
         end
      end
   end

   // Queues a command of up to three runs, loads the model with the run
   // latencies and expected records, then waits for the first start pulse.
   task automatic applyStimulus(input int runs, input int l0, input int l1, input int l2);
      int   lats[3];
      int   eff;
      int   n;
      rec_t r;
      lats = '{l0, l1, l2};
      eff  = (runs == 0) ? 1 : runs;
      got_q.delete();
      for (int i = 0; i < eff; i++) begin
         acc_lat_q.push_back(lats[i]);
         r.index = i;
         if (lats[i] == 0 || lats[i] + 1 > TO) begin
            r.status = 1;
            r.cycles = TO;
         end else begin
            r.status = 0;
            r.cycles = lats[i] + 1;
         end
         exp_q.push_back(r);
      end
      n = 0;
      @(negedge clock);
      while (!cmd_ready && n < 50) begin
         @(negedge clock);
         n++;
      end
      checkOutput("cmd_ready_wait", cmd_ready, 1);
      cmd_runs  = IW'(runs);
      cmd_valid = 1'b1;
      @(posedge clock);
      #1 cmd_valid = 1'b0;
      n = 0;
      do begin
         @(negedge clock);
         n++;
      end while (!acc_start_port && n < 20);
      checkOutput("accept_to_start", longint'(n), longint'(RST + 1));
      checkOutput("busy_in_start", busy, 1);
      checkOutput("ready_in_start", cmd_ready, 0);
   endtask

   task automatic waitIdle(input int budget);
      int n;
      n = 0;
      while ((busy || exp_q.size() > 0) && n < budget) begin
         @(negedge clock);
         n++;
      end
      checkOutput("run_completes", (busy || exp_q.size() > 0) ? 1 : 0, 0);
      @(negedge clock);
      checkOutput("idle_ready", cmd_ready, 1);
      checkOutput("idle_busy", busy, 0);
   endtask

   task automatic checkResetValues(input string tag);
      checkOutput({tag, "_cmd_ready"}, cmd_ready, 0);
      checkOutput({tag, "_acc_reset"}, acc_reset, 0);
      checkOutput({tag, "_acc_start"}, acc_start_port, 0);
      checkOutput({tag, "_res_valid"}, res_valid, 0);
      checkOutput({tag, "_res_status"}, res_status, 0);
      checkOutput({tag, "_res_cycles"}, res_cycles, 0);
      checkOutput({tag, "_res_index"}, res_index, 0);
      checkOutput({tag, "_busy"}, busy, 0);
      checkOutput({tag, "_spurious"}, spurious_done, 0);
   endtask

   initial begin
      int n;
      reset     = 1'b1;
      cmd_valid = 1'b0;
      cmd_runs  = '0;
      res_ready = 1'b1;
      #1;
      checkResetValues("por");
      #24;
      @(posedge clock);
      #1 reset = 1'b0;
      @(posedge clock);
      #1;
      checkOutput("ready_after_reset", cmd_ready, 1);
      checkOutput("acc_reset_idle", acc_reset, 1);

      $display("[TB] single run, done 9 cycles after start");
      applyStimulus(1, 9, 0, 0);
      waitIdle(200);
      checkRecord(0, 0, 10, 0);
      checkOutput("no_spurious", spurious_done, 0);

      $display("[TB] three runs, latencies 5/7/5");
      applyStimulus(3, 5, 7, 5);
      waitIdle(300);
      checkRecord(0, 0, 6, 0);
      checkRecord(1, 0, 8, 1);
      checkRecord(2, 0, 6, 2);

      $display("[TB] two runs that never finish");
      applyStimulus(2, 0, 0, 0);
      waitIdle(400);
      checkRecord(0, 1, TO, 0);
      checkRecord(1, 1, TO, 1);

      $display("[TB] zero run count, done on the last allowed cycle");
      applyStimulus(0, TO - 1, 0, 0);
      waitIdle(200);
      checkRecord(0, 0, TO, 0);

      $display("[TB] backpressure on the first record");
      applyStimulus(2, 3, 4, 0);
      res_ready = 1'b0;
      n = 0;
      while (!res_valid && n < 50) begin
         @(negedge clock);
         n++;
      end
      checkOutput("bp_record_arrives", res_valid, 1);
      repeat (20) @(negedge clock);
      checkOutput("bp_valid_held", res_valid, 1);
      checkOutput("bp_cycles_held", res_cycles, 4);
      checkOutput("bp_index_held", res_index, 0);
      res_ready = 1'b1;
      waitIdle(200);
      checkRecord(0, 0, 4, 0);
      checkRecord(1, 0, 5, 1);

      $display("[TB] done pulse while idle");
      @(posedge clock);
      #1 inject_done = 1'b1;
      @(posedge clock);
      #1 inject_done = 1'b0;
      exp_spurious = 1'b1;
      repeat (5) @(negedge clock);
      checkOutput("spurious_set", spurious_done, 1);
      applyStimulus(1, 2, 0, 0);
      waitIdle(200);
      checkRecord(0, 0, 3, 0);
      checkOutput("spurious_sticky", spurious_done, 1);

      $display("[TB] reset in the middle of a run");
      applyStimulus(1, 0, 0, 0);
      repeat (5) @(negedge clock);
      checkOutput("midrun_busy", busy, 1);
      #2 reset = 1'b1;
      exp_q.delete();
      acc_lat_q.delete();
      exp_spurious = 1'b0;
      #1;
      checkResetValues("midrun");
      @(posedge clock);
      #1 reset = 1'b0;
      @(posedge clock);
      #1;
      checkOutput("ready_after_midrun", cmd_ready, 1);
      applyStimulus(1, 6, 0, 0);
      waitIdle(200);
      checkRecord(0, 0, 7, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
